// File: rtl/tdm_demux_1ton.sv
// Receive end of a TDM link: splits an interleaved sample stream into registered per-channel words.
// Optional macro TDM_DEMUX_FRAME_LATCH_EN: ch_out updates only as complete frames.
module tdm_demux_1ton #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 2,
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [N_CH*DATA_W-1:0]   ch_out,
    output logic [N_CH-1:0]          ch_strobe,
    output logic                     frame_done,
    output logic                     locked,
    output logic                     sync_err
);

    typedef enum logic {HUNT, LOCK} state_t;

    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                   state_reg;
    state_t                   state_next;
    logic [CNT_W-1:0]         ch_cnt_reg;
    logic [CNT_W-1:0]         ch_cnt_next;
    logic [N_CH*DATA_W-1:0]   ch_out_reg;
    logic [N_CH-1:0]          ch_strobe_reg;
    logic                     frame_done_reg;
    logic                     locked_reg;
    logic                     sync_err_reg;

    logic                     wr_en;
    logic [CNT_W-1:0]         wr_sel;
    logic                     frame_done_next;
    logic                     sync_err_next;
    logic [N_CH-1:0]          ch_strobe_next;
    logic [N_CH*DATA_W-1:0]   write_base;
    logic [N_CH*DATA_W-1:0]   merged;

    // Sequencing: decide which channel (if any) this sample lands on.
    always_comb begin
        wr_en           = 1'b0;
        wr_sel          = '0;
        frame_done_next = 1'b0;
        sync_err_next   = 1'b0;
        state_next      = state_reg;
        ch_cnt_next     = ch_cnt_reg;
        if (din_valid) begin
            case (state_reg)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en       = 1'b1;
                        ch_cnt_next = CNT_ONE;
                        state_next  = LOCK;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        // Early sync resyncs the counter onto channel 0.
                        wr_en         = 1'b1;
                        ch_cnt_next   = CNT_ONE;
                        sync_err_next = (ch_cnt_reg != '0);
                    end else if (ch_cnt_reg == '0) begin
                        sync_err_next = 1'b1;
                        ch_cnt_next   = '0;
                        state_next    = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        wr_sel = ch_cnt_reg;
                        if (ch_cnt_reg == LAST_CH) begin
                            frame_done_next = 1'b1;
                            ch_cnt_next     = '0;
                        end else begin
                            ch_cnt_next = ch_cnt_reg + CNT_ONE;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    logic [N_CH*DATA_W-1:0] shadow_reg;
    assign write_base = shadow_reg;
`else
    assign write_base = ch_out_reg;
`endif

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_strobe_next[gi] = wr_en && (wr_sel == CNT_W'(gi));
            assign merged[gi*DATA_W +: DATA_W] =
                ch_strobe_next[gi] ? din : write_base[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HUNT;
            ch_cnt_reg     <= '0;
            ch_out_reg     <= '0;
            ch_strobe_reg  <= '0;
            frame_done_reg <= 1'b0;
            locked_reg     <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ch_cnt_reg     <= ch_cnt_next;
            ch_strobe_reg  <= ch_strobe_next;
            frame_done_reg <= frame_done_next;
            locked_reg     <= (state_next == LOCK);
            sync_err_reg   <= sync_err_next;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
            if (frame_done_next) begin
                ch_out_reg <= merged;
            end
`else
            ch_out_reg <= merged;
`endif
        end
    end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    // Shadow collects the frame in progress; ch_out sees it only when complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else begin
            shadow_reg <= merged;
        end
    end
`endif

    assign ch_out     = ch_out_reg;
    assign ch_strobe  = ch_strobe_reg;
    assign frame_done = frame_done_reg;
    assign locked     = locked_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux_1ton.sv
// Randomized + directed bench for tdm_demux_1ton against a frame-position reference model.
module tb_tdm_demux_1ton;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 2;
    localparam int DATA_W = 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [DATA_W-1:0]      din;
    logic                   din_valid;
    logic                   frame_sync;
    logic [N_CH*DATA_W-1:0] ch_out;
    logic [N_CH-1:0]        ch_strobe;
    logic                   frame_done;
    logic                   locked;
    logic                   sync_err;

    int total = 0;
    int bad   = 0;

    // Reference model: frame position and output image.
    bit                     m_locked;
    int                     m_pos;
    logic [N_CH*DATA_W-1:0] m_out;
    logic [N_CH*DATA_W-1:0] m_shadow;
    logic [N_CH-1:0]        e_strobe;
    bit                     e_done;
    bit                     e_err;

    tdm_demux_1ton #(.N_CH(N_CH), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .ch_strobe  (ch_strobe),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_pos = 0; m_out = '0; m_shadow = '0;
        e_strobe = '0; e_done = 0; e_err = 0;
    endtask

    task automatic model_write(input int k, input logic [DATA_W-1:0] d);
        e_strobe[k] = 1'b1;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
        m_shadow[k*DATA_W +: DATA_W] = d;
`else
        m_out[k*DATA_W +: DATA_W] = d;
`endif
    endtask

    task automatic model_step(input logic v, input logic fs, input logic [DATA_W-1:0] d);
        e_strobe = '0; e_done = 0; e_err = 0;
        if (!v) return;
        if (fs) begin
            e_err = m_locked && (m_pos != 0);
            model_write(0, d);
            m_pos = 1;
            m_locked = 1;
        end else if (m_locked) begin
            if (m_pos == 0) begin
                e_err = 1;
                m_locked = 0;
            end else begin
                model_write(m_pos, d);
                if (m_pos == N_CH - 1) begin
                    e_done = 1;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
                    m_out = m_shadow;
`endif
                end
                m_pos = (m_pos + 1) % N_CH;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ch_out"}, 32'(ch_out), 32'(m_out));
        chk({tag, ".strobe"}, 32'(ch_strobe), 32'(e_strobe));
        chk({tag, ".done"}, 32'(frame_done), 32'(e_done));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".err"}, 32'(sync_err), 32'(e_err));
    endtask

    task automatic cyc(input string tag, input logic v, input logic fs, input logic [DATA_W-1:0] d);
        @(negedge clk);
        din_valid = v; frame_sync = fs; din = d;
        model_step(v, fs, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic frame(input string tag, input logic [N_CH-1:0] bits);
        for (int k = 0; k < N_CH; k++)
            cyc(tag, 1'b1, (k == 0), bits[k]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 0; frame_sync = 0; din = '0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 0; frame_sync = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Unsynced samples are ignored.
        for (int i = 0; i < 3; i++) cyc("hunt", 1'b1, 1'b0, 1'b1);

        // Basic frame 1,0,1,1.
        frame("frame", 4'b1101);
        chk("frame_1101", 32'(ch_out), 32'h0000_000d);

        // Same frame with a 2-cycle gap after ch1.
        cyc("gap", 1'b1, 1'b1, 1'b1);
        cyc("gap", 1'b1, 1'b0, 1'b0);
        cyc("gap", 1'b0, 1'b0, 1'b1);
        cyc("gap", 1'b0, 1'b1, 1'b1);
        cyc("gap", 1'b1, 1'b0, 1'b1);
        cyc("gap", 1'b1, 1'b0, 1'b1);
        chk("gap_1101", 32'(ch_out), 32'h0000_000d);

        // Early sync at ch2, next sample lands on ch1.
        cyc("early", 1'b1, 1'b1, 1'b0);
        cyc("early", 1'b1, 1'b0, 1'b0);
        cyc("early", 1'b1, 1'b1, 1'b1);
        chk("early_err", 32'(sync_err), 32'h1);
        cyc("early", 1'b1, 1'b0, 1'b1);
        chk("early_ch1", 32'(ch_strobe), 32'h2);
        cyc("early", 1'b1, 1'b0, 1'b0);
        cyc("early", 1'b1, 1'b0, 1'b0);

        // Full frame then missing sync.
        frame("full", 4'b0110);
        cyc("miss", 1'b1, 1'b0, 1'b1);
        chk("miss_unlock", 32'(locked), 32'h0);

        // Reset mid-frame.
        cyc("mid", 1'b1, 1'b1, 1'b1);
        cyc("mid", 1'b1, 1'b0, 1'b1);
        do_reset();

        // Randomized traffic, sync mostly aligned.
        for (int i = 0; i < 600; i++) begin
            logic v, fs, d;
            v  = ($urandom_range(0, 9) < 7);
            if (!m_locked || m_pos == 0)
                fs = ($urandom_range(0, 9) < 9);
            else
                fs = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) fs = ~fs;
            d  = 1'($urandom);
            cyc("rand", v, fs, d);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
